instr_assembler: RTL and testbench
==================================

Name: instr_assembler

Overview:
Parametrised successor to the processor's byte-enable instruction register. It assembles a NUM_BYTES-wide instruction from sequential BYTE_W-bit memory reads. An internal lane counter replaces the external one-hot enables, and a valid/ready handshake runs on both sides. It sits between the 8-bit memory data path and the multicycle control FSM, which consumes the complete instruction via instrAck.

Parameters:
BYTE_W, 8, width of one incoming byte/lane
NUM_BYTES, 4, lanes per instruction (>=2); instruction width = BYTE_W*NUM_BYTES
BIG_ENDIAN, 1, 1: first accepted byte lands in the MS lane; 0: first byte lands in the LS lane

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
byteIn  in  BYTE_W  incoming instruction byte
byteValid  in  1  byteIn valid this cycle
byteReady  out  1  assembler can accept a byte this cycle
flush  in  1  synchronous abort of a partial or complete fetch
instrAck  in  1  control FSM consumes the complete instruction
instrValid  out  1  Instr holds a complete instruction
Instr  out  BYTE_W*NUM_BYTES  assembled instruction register
byteCount  out  clog2(NUM_BYTES+1)  lanes filled in the current fetch

Behaviour:
- One clock; reset is asynchronous and active-high (ports clock, reset).
- Reset: Instr=0, byteCount=0, instrValid=0, state=FILL, byteReady=1.
- States: FILL (collecting bytes) and FULL (instruction complete, held).
- byteReady = (state==FILL) && !flush. It is combinational from state and flush only.
- Accept = byteValid && byteReady.
- On accept, byteIn is written into lane L at the clock edge; all other lanes hold.
  - BIG_ENDIAN=1: L = NUM_BYTES-1-byteCount.
  - BIG_ENDIAN=0: L = byteCount.
- byteCount increments on each accept.
- Accept with byteCount==NUM_BYTES-1 at the edge:
  - state becomes FULL.
  - instrValid=1 and byteCount=NUM_BYTES, both in the cycle after the last byte (1-cycle latency).
- FULL:
  - Instr is frozen and byteReady=0; byteValid is ignored, not buffered.
  - instrAck=1 moves to FILL with byteCount=0 and instrValid=0.
  - Instr keeps its old contents until overwritten lane by lane.
  - instrAck in the same cycle as byteValid: the byte is NOT accepted. The first new byte can be accepted the cycle after ack.
- instrAck in FILL has no effect.
- flush (any state): next state FILL, byteCount=0, instrValid=0, and Instr is retained. flush has priority over accept and ack in the same cycle.
- Lanes written in an aborted partial fetch keep their new values until overwritten.
- Asynchronous reset mid-fetch returns immediately to the reset values.
- No wrap-around: byteCount never exceeds NUM_BYTES; FULL is the only exit from the last lane.

Decomposition:
- Shared package instr_asm_pkg holds:
  - the state enum {FILL, FULL};
  - the count-width constant function (clog2);
  - the lane-index function lane_sel(count, BIG_ENDIAN).
- One natural sub-module: instr_byte_lane, a BYTE_W register with write-enable and async reset. It is instantiated NUM_BYTES times by a generate loop; the top holds the FSM and counter.

Test Plan:
- Default params, reset released, bytes 0x12,0x34,0x56,0x78 on 4 consecutive cycles with byteValid=1:
  - byteCount goes 1,2,3,4.
  - Cycle after the 4th byte: instrValid=1, Instr=0x12345678, byteReady=0.
- BIG_ENDIAN=0, same bytes -> Instr=0x78563412. Then instrAck=1 for one cycle -> instrValid=0, byteCount=0, byteReady=1, Instr still 0x78563412.
- In FULL, drive byteValid=1 with byteIn=0xAA for 3 cycles and no ack -> Instr unchanged, byteCount stays 4, byteReady stays 0.
- After 2 bytes (0x11,0x22), assert flush together with byteValid=1/0x33 -> byte rejected, byteCount=0, instrValid=0. The next 4 bytes 0xDE,0xAD,0xBE,0xEF give Instr=0xDEADBEEF.
- Gapped input: byteValid toggled 1,0,0,1,1,0,1 -> exactly 4 accepts, instrValid asserts one cycle after the 4th. instrAck coincident with a byteValid does not consume that byte.
- Assert reset asynchronously mid-edge after 3 bytes -> Instr=0, byteCount=0, instrValid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_asm_pkg.sv
// Shared types and helpers for the instruction assembler: FSM state,
// counter width and byte-to-lane mapping.
package instr_asm_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Counter must represent 0..n inclusive, so it needs clog2(n+1) bits.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int lane_sel(input int count, input int num_bytes, input int big_endian);
        return (big_endian != 0) ? (num_bytes - 1 - count) : count;
    endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Byte-in / instruction-out bundle between memory data path, assembler and control FSM.
interface instr_assembler_if #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 4
);
    import instr_asm_pkg::*;

    localparam int CNT_W = cnt_w(NUM_BYTES);

    logic [BYTE_W-1:0]           byteIn;
    logic                        byteValid;
    logic                        byteReady;
    logic                        flush;
    logic                        instrAck;
    logic                        instrValid;
    logic [BYTE_W*NUM_BYTES-1:0] Instr;
    logic [CNT_W-1:0]            byteCount;

    modport master (
        output byteIn, byteValid, flush, instrAck,
        input  byteReady, instrValid, Instr, byteCount
    );

    modport slave (
        input  byteIn, byteValid, flush, instrAck,
        output byteReady, instrValid, Instr, byteCount
    );

endinterface

// File: rtl/instr_byte_lane.sv
// One byte lane of the instruction register: write-enabled hold register
// with asynchronous clear.
module instr_byte_lane #(
    parameter int BYTE_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [BYTE_W-1:0] d_i,
    output logic [BYTE_W-1:0] q_o
);

    logic [BYTE_W-1:0] lane_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
        end else if (we_i) begin
            lane_q <= d_i;
        end
    end

    assign q_o = lane_q;

endmodule

// File: rtl/instr_assembler.sv
// Assembles NUM_BYTES sequential bytes into one instruction word and holds
// it until the control FSM acknowledges it.
module instr_assembler
    import instr_asm_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int NUM_BYTES  = 4,
    parameter int BIG_ENDIAN = 1
) (
    input  logic             clock,
    input  logic             reset,
    instr_assembler_if.slave bus
);

    localparam int CNT_W = cnt_w(NUM_BYTES);

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic                        vld_q;
    logic                        accept;
    logic [NUM_BYTES-1:0]        lane_we;
    logic [BYTE_W*NUM_BYTES-1:0] instr_w;

    assign bus.byteReady = (state_q == FILL) && !bus.flush;
    assign accept        = bus.byteValid && bus.byteReady;
    assign cnt_d         = cnt_q + CNT_W'(1);

    // flush outranks both accept and ack; FULL only leaves through ack or flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
                            state_q <= FULL;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.instrAck) begin
                        state_q <= FILL;
                        cnt_q   <= '0;
                        vld_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        assign lane_we[i] = accept && (lane_sel(int'(cnt_q), NUM_BYTES, BIG_ENDIAN) == i);

        instr_byte_lane #(
            .BYTE_W (BYTE_W)
        ) u_lane (
            .clock (clock),
            .reset (reset),
            .we_i  (lane_we[i]),
            .d_i   (bus.byteIn),
            .q_o   (instr_w[i*BYTE_W +: BYTE_W])
        );
    end

    assign bus.Instr      = instr_w;
    assign bus.instrValid = vld_q;
    assign bus.byteCount  = cnt_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Randomised and directed bench for instr_assembler, run on a big-endian and
// a little-endian instance side by side against a byte-queue reference model.
module tb_instr_assembler;

    localparam int N = 4;

    logic clock;
    logic reset;

    instr_assembler_if #(.BYTE_W(8), .NUM_BYTES(N)) if_be ();
    instr_assembler_if #(.BYTE_W(8), .NUM_BYTES(N)) if_le ();

    instr_assembler #(.BYTE_W(8), .NUM_BYTES(N), .BIG_ENDIAN(1)) u_be (
        .clock (clock),
        .reset (reset),
        .bus   (if_be.slave)
    );

    instr_assembler #(.BYTE_W(8), .NUM_BYTES(N), .BIG_ENDIAN(0)) u_le (
        .clock (clock),
        .reset (reset),
        .bus   (if_le.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: instruction image per endianness, fill count and full flag.
    logic [31:0] m_instr [2];
    int          m_cnt;
    bit          m_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic f, input logic a);
        if_be.byteIn = b; if_be.byteValid = v; if_be.flush = f; if_be.instrAck = a;
        if_le.byteIn = b; if_le.byteValid = v; if_le.flush = f; if_le.instrAck = a;
    endtask

    task automatic model_reset();
        m_instr[0] = '0;
        m_instr[1] = '0;
        m_cnt      = 0;
        m_full     = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] b, input logic v, input logic f, input logic a);
        if (f) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end else if (!m_full) begin
            if (v) begin
                m_instr[0][(N-1-m_cnt)*8 +: 8] = b;
                m_instr[1][m_cnt*8 +: 8]       = b;
                m_cnt++;
                if (m_cnt == N) m_full = 1'b1;
            end
        end else if (a) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".vld_be"}, 32'(if_be.instrValid), 32'(m_full));
        check({tag, ".vld_le"}, 32'(if_le.instrValid), 32'(m_full));
        check({tag, ".cnt_be"}, 32'(if_be.byteCount), 32'(m_cnt));
        check({tag, ".cnt_le"}, 32'(if_le.byteCount), 32'(m_cnt));
        check({tag, ".instr_be"}, if_be.Instr, m_instr[0]);
        check({tag, ".instr_le"}, if_le.Instr, m_instr[1]);
    endtask

    task automatic step(input string tag, input logic [7:0] b, input logic v, input logic f, input logic a);
        @(negedge clock);
        drive(b, v, f, a);
        #1;
        check({tag, ".rdy_be"}, 32'(if_be.byteReady), 32'(!m_full && !f));
        check({tag, ".rdy_le"}, 32'(if_le.byteReady), 32'(!m_full && !f));
        @(posedge clock);
        model_edge(b, v, f, a);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] bytes [4];
        logic [6:0] gap;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.rdy", 32'(if_be.byteReady), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            step("fill", bytes[i], 1'b1, 1'b0, 1'b0);
            check("fill.count", 32'(if_be.byteCount), 32'(i + 1));
        end
        check("fill.be_const", if_be.Instr, 32'h12345678);
        check("fill.le_const", if_le.Instr, 32'h78563412);
        check("fill.rdy_full", 32'(if_be.byteReady), 32'd0);

        for (int i = 0; i < 3; i++) step("hold", 8'hAA, 1'b1, 1'b0, 1'b0);
        check("hold.be_const", if_be.Instr, 32'h12345678);

        step("ack", 8'h00, 1'b0, 1'b0, 1'b1);
        check("ack.le_kept", if_le.Instr, 32'h78563412);
        step("ack_fill", 8'h00, 1'b0, 1'b0, 1'b1);

        step("part", 8'h11, 1'b1, 1'b0, 1'b0);
        step("part", 8'h22, 1'b1, 1'b0, 1'b0);
        step("flush", 8'h33, 1'b1, 1'b1, 1'b0);
        check("flush.count", 32'(if_be.byteCount), 32'd0);
        bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
        for (int i = 0; i < 4; i++) step("refill", bytes[i], 1'b1, 1'b0, 1'b0);
        check("refill.be_const", if_be.Instr, 32'hDEADBEEF);
        step("ack2", 8'h00, 1'b0, 1'b0, 1'b1);

        gap = 7'b1011001;
        for (int i = 0; i < 7; i++) step("gap", 8'(8'h40 + i), gap[i], 1'b0, 1'b0);
        check("gap.vld", 32'(if_be.instrValid), 32'd1);
        check("gap.be_const", if_be.Instr, 32'h40434446);
        step("gap_ack", 8'h99, 1'b1, 1'b0, 1'b1);
        step("gap_next", 8'h5A, 1'b1, 1'b0, 1'b0);
        check("gap_next.count", 32'(if_be.byteCount), 32'd1);

        for (int i = 0; i < 400; i++) begin
            step("rand", 8'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end

        step("pre_rst", 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("pre_rst", 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.rdy", 32'(if_be.byteReady), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step("post_rst", 8'($urandom), 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
